// File: rtl/add_arbiter_if.sv
// add_arbiter_if: request/response bundle for the two-requester add arbiter.
// slave  = arbiter side (takes requests, produces responses).
// master = requester/consumer side.
interface add_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_chain;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_chain;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_id;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_chain,
        input  req1_valid, req1_a, req1_b, req1_chain,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_chain,
        output req1_valid, req1_a, req1_b, req1_chain,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_id
    );
endinterface

// File: rtl/add_arbiter.sv
// add_arbiter: two requesters share one 32-bit adder.
// IDLE grants one valid requester and latches its operands, CALC registers the
// 33-bit sum, HOLD presents the result until the consumer takes it.
// FAIR_MODE=1 alternates grants on ties, FAIR_MODE=0 gives req0 fixed priority.
// Optional feature macro: ADD_CARRY_CHAIN_EN (per-requester stored carry used
// as carry-in when that requester's chain bit is set).
module add_arbiter #(
    parameter int FAIR_MODE = 1
) (
    input logic          clk,
    input logic          rst_n,
    add_arbiter_if.slave bus
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q;       // index of the requester granted last
    logic                gnt_id;       // requester that would be granted now
    logic                any_valid;
    logic                accept;
    logic                ready0, ready1;
    logic                cin_sel;
    logic                handshake;

    logic [DATA_W-1:0]   a_q, b_q;
    logic                cin_q, id_q;

    logic [DATA_W-1:0]   sum_q;
    logic                cout_q;
    logic                rsp_id_q;
    logic                rsp_valid_q;

    // 33-bit add so the wrap-around lands in bit 32 as the carry out
    function automatic logic [DATA_W:0] add_wide(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic              cin);
        return {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    endfunction

    // Arbitration: pick which requester would be served this cycle
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        gnt_id    = 1'b0;
        if (FAIR_MODE != 0) begin
            if (bus.req0_valid && bus.req1_valid) gnt_id = ~last_q;
            else                                  gnt_id = bus.req1_valid;
        end else begin
            gnt_id = ~bus.req0_valid;
        end
    end

`ifdef ADD_CARRY_CHAIN_EN
    logic [1:0] carry_q;

    assign cin_sel = gnt_id ? (bus.req1_chain & carry_q[1])
                            : (bus.req0_chain & carry_q[0]);

    // Remember each requester's carry out once its result is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= 2'b00;
        end else if (handshake) begin
            carry_q[rsp_id_q] <= cout_q;
        end
    end
`else
    logic unused_chain;

    assign cin_sel      = 1'b0;
    assign unused_chain = bus.req0_chain ^ bus.req1_chain;
`endif

    // Next-state and handshake outputs; ready only ever offered from IDLE
    always_comb begin
        state_d = state_q;
        ready0  = 1'b0;
        ready1  = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    ready0  = ~gnt_id;
                    ready1  = gnt_id;
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: state_d = HOLD;
            HOLD: begin
                if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            ready0 = 1'b0;
            ready1 = 1'b0;
            accept = 1'b0;
        end
    end

    assign handshake = (state_q == HOLD) && rsp_valid_q && bus.rsp_ready;

    // Control state: FSM, round-robin pointer and response valid.
    // rsp_valid rises one edge after the sum register loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) last_q <= gnt_id;
            if (state_q == HOLD && !rsp_valid_q) rsp_valid_q <= 1'b1;
            else if (handshake)                  rsp_valid_q <= 1'b0;
        end
    end

    // Operand capture on acceptance; contents are don't-care until then
    always_ff @(posedge clk) begin
        if (accept) begin
            if (gnt_id) begin
                a_q <= bus.req1_a;
                b_q <= bus.req1_b;
            end else begin
                a_q <= bus.req0_a;
                b_q <= bus.req0_b;
            end
            cin_q <= cin_sel;
            id_q  <= gnt_id;
        end
    end

    // Result register: loaded only in CALC, so it stays put through HOLD
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q    <= '0;
            cout_q   <= 1'b0;
            rsp_id_q <= 1'b0;
        end else if (state_q == CALC) begin
            {cout_q, sum_q} <= add_wide(a_q, b_q, cin_q);
            rsp_id_q        <= id_q;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_sum    = sum_q;
    assign bus.rsp_cout   = cout_q;
    assign bus.rsp_id     = rsp_id_q;

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter: FAIR_MODE, 1, 1 = round-robin grant between requesters; 0 = fixed priority to requester 0.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have ports: req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-006 SHALL have ports: req0_ready / req1_ready  output  1  operation accepted this cycle when valid and ready are both high.
REQ-007 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  32  operands.
REQ-008 SHALL have ports: req0_chain / req1_chain  input  1  use the stored carry of that requester as carry-in.
REQ-009 SHALL have port: rsp_valid  output  1  result available.
REQ-010 SHALL have port: rsp_ready  input  1  consumer takes the result.
REQ-011 SHALL have ports: rsp_sum  output  32; rsp_cout  output  1; rsp_id  output  1 (requester index).

Function
REQ-012 SHALL implement FSM states IDLE, CALC and HOLD.
REQ-013 SHALL drive req*_ready in IDLE only, combinationally, to exactly one valid requester (the grant); both ready signals low in CALC and HOLD.
REQ-014 SHALL, with FAIR_MODE=1, grant the requester not granted last when both are valid, and the sole valid requester otherwise.
REQ-015 SHALL, with FAIR_MODE=0, always grant req0 when req0_valid is high.
REQ-016 SHALL, on acceptance at edge T, latch operands, carry-in and id, and move IDLE->CALC.
REQ-017 SHALL, in CALC, compute the 33-bit sum {cout,sum} = a + b + cin, register it, and move CALC->HOLD; rsp_valid rises after edge T+2.
REQ-018 SHALL hold rsp_valid, rsp_sum, rsp_cout and rsp_id stable in HOLD until rsp_valid && rsp_ready, then move HOLD->IDLE and clear rsp_valid.
REQ-019 SHALL accept the next request no earlier than the IDLE cycle after the handshake; there is no bypass path from HOLD.
REQ-020 SHALL update the round-robin pointer only on acceptance, never on mere valid.
REQ-021 SHALL wrap modulo 2^32 in sum; the overflow bit appears only on rsp_cout.
REQ-022 SHALL ignore requester inputs, and treat rsp_ready as don't-care, outside the states in which they are sampled.

Reset
REQ-023 SHALL, when rst_n is low at a clock edge, force state IDLE, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, pointer = "last granted = 1" (req0 wins first tie), and clear all carry flags.
REQ-024 SHALL discard an operation in CALC or HOLD when reset occurs, and produce no response for it.
REQ-025 SHALL hold both req*_ready low while rst_n is low.

Configuration
REQ-026 SHALL, with ADD_CARRY_CHAIN_EN defined, keep one carry flag per requester, loaded with rsp_cout when that requester's result handshakes; carry-in = that flag if chain=1, else 0.
REQ-027 SHALL, without ADD_CARRY_CHAIN_EN, use carry-in 0, ignore req*_chain, and have no carry-flag registers.

Verification
REQ-028 SHALL cover: single op, req0 a=0x0000_0005 b=0x0000_0003 -> rsp_valid rises 2 edges after accept; sum=0x8, cout=0, id=0.
REQ-029 SHALL cover: both valid continuously, FAIR_MODE=1, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0.
REQ-030 SHALL cover: both valid, FAIR_MODE=0 -> req1 never granted while req0_valid stays high.
REQ-031 SHALL cover: rsp_ready held low 5 cycles -> outputs stable, both ready low, no new accept; accept resumes the cycle after the handshake.
REQ-032 SHALL cover: ADD_CARRY_CHAIN_EN, req1 0xFFFF_FFFF+0x1 (chain=0) then 0x0+0x0 (chain=1) -> sums 0x0/cout=1, then 0x1/cout=0; req0 carry unaffected.
REQ-033 SHALL cover: rst_n low during HOLD -> rsp_valid=0 next edge, no response emitted, next tie grants req0.
